// File: rtl/alu_issue.sv
`default_nettype none
// alu_issue: issues one request at a time to an external registered ALU and returns a tagged response.
// Optional macro ALU_ISSUE_RESP_FIFO_EN places a 2-entry response FIFO in front of the resp_* port.
module alu_issue #(
   parameter int         WORD_SIZE = 16,
   parameter int         TAG_W     = 4,
   parameter logic [3:0] ALU_ADD   = 4'h0,
   parameter logic [3:0] ALU_SUB   = 4'h1,
   parameter logic [3:0] ALU_MUL   = 4'h2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [3:0]           req_op,
   input  logic [WORD_SIZE-1:0] req_a,
   input  logic [WORD_SIZE-1:0] req_b,
   input  logic [TAG_W-1:0]     req_tag,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [WORD_SIZE-1:0] resp_data,
   output logic [TAG_W-1:0]     resp_tag,
   output logic                 resp_err,
   output logic [3:0]           alu_op,
   output logic [WORD_SIZE-1:0] alu_in1,
   output logic [WORD_SIZE-1:0] alu_in2,
   output logic                 alu_enable,
   input  logic [WORD_SIZE-1:0] alu_out
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t               r_state;
   logic                 r_req_ready;
   logic                 r_alu_enable;
   logic                 r_illegal;
   logic [3:0]           r_alu_op;
   logic [WORD_SIZE-1:0] r_alu_in1;
   logic [WORD_SIZE-1:0] r_alu_in2;
   logic [TAG_W-1:0]     r_tag;

   logic                 w_req_fire;
   logic                 w_legal;
   logic                 w_room;

   assign w_req_fire = req_valid && r_req_ready;
   assign w_legal    = (req_op == ALU_ADD) || (req_op == ALU_SUB) || (req_op == ALU_MUL);

   assign req_ready  = r_req_ready;
   assign alu_enable = r_alu_enable;
   assign alu_op     = r_alu_op;
   assign alu_in1    = r_alu_in1;
   assign alu_in2    = r_alu_in2;

`ifdef ALU_ISSUE_RESP_FIFO_EN
   logic                 w_push;
   logic                 w_pop;
   logic                 w_push_err;
   logic [WORD_SIZE-1:0] w_push_data;
   logic [1:0]           w_count_next;
   logic [1:0]           r_count;
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [WORD_SIZE-1:0] r_fifo_data [2];
   logic [TAG_W-1:0]     r_fifo_tag  [2];
   logic [1:0]           r_fifo_err;

   // Illegal requests are pushed from ISSUE, one cycle before a legal one would reach CAPTURE.
   assign w_push       = (r_state == S_CAPTURE) || ((r_state == S_ISSUE) && r_illegal);
   assign w_push_data  = r_illegal ? '0 : alu_out;
   assign w_push_err   = r_illegal;
   assign w_pop        = (r_count != 2'd0) && resp_ready;
   assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
   // Nothing is in flight whenever the FSM sits in IDLE, so occupancy alone gates acceptance.
   assign w_room       = (w_count_next < 2'd2);

   assign resp_valid = (r_count != 2'd0);
   assign resp_data  = r_fifo_data[r_rd_ptr];
   assign resp_tag   = r_fifo_tag[r_rd_ptr];
   assign resp_err   = r_fifo_err[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= 2'd0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_fifo_err <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_tag[i]  <= '0;
         end
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_tag[r_wr_ptr]  <= r_tag;
            r_fifo_err[r_wr_ptr]  <= w_push_err;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= w_count_next;
      end
   end
`else
   logic                 r_resp_valid;
   logic                 r_resp_err;
   logic [WORD_SIZE-1:0] r_resp_data;
   logic [TAG_W-1:0]     r_resp_tag;

   assign w_room     = 1'b1;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_tag   = r_resp_tag;
   assign resp_err   = r_resp_err;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b0;
         r_alu_enable <= 1'b0;
         r_illegal    <= 1'b0;
         r_alu_op     <= 4'h0;
         r_alu_in1    <= '0;
         r_alu_in2    <= '0;
         r_tag        <= '0;
`ifndef ALU_ISSUE_RESP_FIFO_EN
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_data  <= '0;
         r_resp_tag   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_fire) begin
                  r_req_ready  <= 1'b0;
                  r_tag        <= req_tag;
                  r_illegal    <= !w_legal;
                  r_alu_enable <= w_legal;
                  r_state      <= S_ISSUE;
                  if (w_legal) begin
                     r_alu_op  <= req_op;
                     r_alu_in1 <= req_a;
                     r_alu_in2 <= req_b;
                  end
               end else begin
                  r_req_ready <= w_room;
               end
            end
            S_ISSUE: begin
               r_alu_enable <= 1'b0;
               // An illegal op never touches the ALU and skips CAPTURE.
               if (r_illegal) begin
`ifdef ALU_ISSUE_RESP_FIFO_EN
                  r_state     <= S_IDLE;
                  r_req_ready <= w_room;
`else
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b1;
                  r_resp_data  <= '0;
                  r_resp_tag   <= r_tag;
                  r_state      <= S_RESP;
`endif
               end else begin
                  r_state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
`ifdef ALU_ISSUE_RESP_FIFO_EN
               r_state     <= S_IDLE;
               r_req_ready <= w_room;
`else
               r_resp_valid <= 1'b1;
               r_resp_err   <= 1'b0;
               r_resp_data  <= alu_out;
               r_resp_tag   <= r_tag;
               r_state      <= S_RESP;
`endif
            end
`ifndef ALU_ISSUE_RESP_FIFO_EN
            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
